// File: rtl/usr_pkg.sv
// Shared definitions for the serial/parallel shift controller: register select
// encodings and FSM state encodings.
package usr_pkg;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LEFT  = 2'b01;
  localparam logic [1:0] SEL_RIGHT = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/usr_core.sv
// Universal shift register: hold, shift left, shift right or parallel load per sel.
// Single-cycle update, no flow control; the controller owns sequencing.
module usr_core
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_l,
  input  logic             ser_r,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else begin
      case (sel)
        SEL_LOAD:  q <= par_in;
        SEL_LEFT:  q <= {q[WIDTH-2:0], ser_l};
        SEL_RIGHT: q <= {ser_r, q[WIDTH-1:1]};
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/usr_shift_ctrl.sv
// Command-driven shift controller: loads, shifts min(count,WIDTH) edges, holds result until rsp_ready.
// Commands only accepted in IDLE; optional rotate mode enabled by USR_ROTATE_EN (adds cmd_rot).
module usr_shift_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef USR_ROTATE_EN
  input  logic             cmd_rot,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic             dir_q;
  logic [1:0]       sel;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] cnt_clamp;
  logic             accept;
  logic             out_bit;
  logic             fill;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_DONE);
  assign rsp_data  = q;
  assign accept    = cmd_ready && cmd_valid;
  assign cnt_clamp = (cmd_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_count;
  assign out_bit   = dir_q ? q[0] : q[WIDTH-1];

`ifdef USR_ROTATE_EN
  logic rot_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rot_q <= 1'b0;
    end else if (accept) begin
      rot_q <= cmd_rot;
    end
  end

  // Rotate feeds the departing bit back into the vacated end.
  assign fill = rot_q ? out_bit : ser_in;
`else
  assign fill = ser_in;
`endif

  always_comb begin
    sel = SEL_HOLD;
    if (accept) begin
      sel = SEL_LOAD;
    end else if (state == ST_SHIFT) begin
      sel = dir_q ? SEL_RIGHT : SEL_LEFT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      dir_q     <= 1'b0;
      ser_out   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            remaining <= cnt_clamp;
            dir_q     <= cmd_dir;
            state     <= (cnt_clamp == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          ser_out   <= out_bit;
          remaining <= remaining - 1'b1;
          if (remaining == CNT_W'(1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  usr_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .sel    (sel),
    .par_in (cmd_data),
    .ser_l  (fill),
    .ser_r  (fill),
    .q      (q)
  );

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Directed, table-driven bench for usr_shift_ctrl at WIDTH=8, plus hand sequences
// for ser_out ordering, backpressure, mid-shift reset and (if enabled) rotate.
module tb_usr_shift_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_dir = 1'b0;
  logic [3:0] cmd_count = '0;
  logic [7:0] cmd_data = '0;
  logic       ser_in = 1'b0;
  logic       ser_out;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       busy;
`ifdef USR_ROTATE_EN
  logic       cmd_rot = 1'b0;
`endif

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  usr_shift_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef USR_ROTATE_EN
    .cmd_rot   (cmd_rot),
`endif
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_count (cmd_count),
    .cmd_data  (cmd_data),
    .ser_in    (ser_in),
    .ser_out   (ser_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       dir;
    logic [3:0] count;
    logic       ser;
    logic [7:0] exp_data;
    logic       exp_so;
    logic       chk_so;
    int         exp_edges;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Offer a command on the next negedge; returns after the accepting edge.
  task automatic send(input logic [7:0] d, input logic dr, input logic [3:0] c, input logic s);
    @(negedge clk);
    cmd_data  = d;
    cmd_dir   = dr;
    cmd_count = c;
    ser_in    = s;
    cmd_valid = 1'b1;
    chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle_after_hs_ready", {31'b0, cmd_ready}, 32'd1);
    chk("idle_after_hs_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int edges;
    logic [7:0] held;

    vecs[0] = '{8'hA5, 1'b0, 4'd3,  1'b1, 8'h2F, 1'b1, 1'b1, 3};
    vecs[1] = '{8'h81, 1'b1, 4'd2,  1'b0, 8'h20, 1'b0, 1'b1, 2};
    vecs[2] = '{8'h3C, 1'b0, 4'd0,  1'b0, 8'h3C, 1'b0, 1'b0, 0};
    vecs[3] = '{8'hFF, 1'b1, 4'd12, 1'b0, 8'h00, 1'b1, 1'b1, 8};
    vecs[4] = '{8'h0F, 1'b0, 4'd15, 1'b1, 8'hFF, 1'b1, 1'b1, 8};
    vecs[5] = '{8'h5A, 1'b1, 4'd1,  1'b1, 8'hAD, 1'b0, 1'b1, 1};
    vecs[6] = '{8'hC3, 1'b0, 4'd8,  1'b0, 8'h00, 1'b1, 1'b1, 8};

    #3;
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", {24'b0, rsp_data}, 32'h00);
    chk("rst_ser_out", {31'b0, ser_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      send(vecs[i].data, vecs[i].dir, vecs[i].count, vecs[i].ser);
      edges = 0;
      while (!rsp_valid && edges < 40) begin
        @(negedge clk);
        edges++;
      end
      chk($sformatf("v%0d_edges", i), edges, vecs[i].exp_edges);
      chk($sformatf("v%0d_data", i), {24'b0, rsp_data}, {24'b0, vecs[i].exp_data});
      if (vecs[i].chk_so) chk($sformatf("v%0d_ser_out", i), {31'b0, ser_out}, {31'b0, vecs[i].exp_so});
      handshake();
    end

    // ser_out ordering on a left shift of 0xA5 with ser_in=1
    send(8'hA5, 1'b0, 4'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("seq_ser_out_%0d", i), {31'b0, ser_out}, (i == 1) ? 32'd0 : 32'd1);
    end
    chk("seq_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("seq_rsp_data", {24'b0, rsp_data}, 32'h2F);

    // Backpressure: hold DONE for 5 cycles with an ignored command pulse
    held = rsp_data;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        cmd_data  = 8'h99;
        cmd_count = 4'd0;
        cmd_valid = 1'b1;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      chk($sformatf("bp_data_%0d", i), {24'b0, rsp_data}, {24'b0, held});
      chk($sformatf("bp_cmd_ready_%0d", i), {31'b0, cmd_ready}, 32'd0);
      chk($sformatf("bp_rsp_valid_%0d", i), {31'b0, rsp_valid}, 32'd1);
    end
    handshake();
    chk("bp_data_after_hs", {24'b0, rsp_data}, 32'h2F);

    // Reset mid-shift: asynchronous clear, operation abandoned
    send(8'hB7, 1'b0, 4'd6, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mid_rst_rsp_data", {24'b0, rsp_data}, 32'h00);
    chk("mid_rst_ser_out", {31'b0, ser_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    edges = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) edges++;
    end
    chk("mid_rst_no_rsp", edges, 0);

`ifdef USR_ROTATE_EN
    cmd_rot = 1'b1;
    send(8'h81, 1'b0, 4'd1, 1'b0);
    @(negedge clk);
    chk("rot_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("rot_rsp_data", {24'b0, rsp_data}, 32'h03);
    cmd_rot = 1'b0;
    handshake();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
